// File: rtl/dma_dev_pkg.sv
// Shared types for the DMA I/O device endpoint.
package dma_dev_pkg;

    typedef enum logic [3:0] {
        StIdle = 4'b0001,
        StReq  = 4'b0010,
        StXfer = 4'b0100,
        StHold = 4'b1000
    } dev_state_e;

    localparam logic DIR_IO2MEM = 1'b0;
    localparam logic DIR_MEM2IO = 1'b1;

endpackage

// File: rtl/dma_dev_fifo.sv
// Synchronous FIFO buffering local-side data for the DMA I/O device.
module dma_dev_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [CW-1:0]     count_q;
    logic              do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    // A pop frees the slot, so a push into a full FIFO is accepted alongside it.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem_q[rptr_q];
    assign count   = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= push_data;
    end

endmodule

// File: rtl/dma_io_device.sv
// Peripheral-side responder of the DMA channel handshake: raises DREQ, moves one
// FIFO entry per completed IOR_N/IOW_N strobe under DACK, and latches terminal count.
module dma_io_device
    import dma_dev_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 8,
    parameter bit          DREQ_HIGH = 1'b1
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   DIR,
    output logic                   DREQ,
    input  logic                   DACK,
    input  logic                   IOR_N,
    input  logic                   IOW_N,
    input  logic                   EOP_N,
    input  logic [DATA_W-1:0]      DB_IN,
    output logic [DATA_W-1:0]      DB_OUT,
    output logic                   DB_OE,
    input  logic                   loc_wvalid,
    input  logic [DATA_W-1:0]      loc_wdata,
    output logic                   loc_wready,
    output logic                   loc_rvalid,
    output logic [DATA_W-1:0]      loc_rdata,
    input  logic                   loc_rready,
    output logic                   tc_flag,
    input  logic                   tc_clear,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    dev_state_e        state_q, state_d;
    logic              dir_q, dir_eff;
    logic              ior_q, iow_q, tc_q;
    logic [DATA_W-1:0] db_lat_q, head, push_data;
    logic              full, empty, rd_beat, wr_beat, beat;
    logic              push, pop, push_ok, pop_ok, req_ok, req_ok_nxt, dreq_act;
    logic [CW-1:0]     cnt_nxt;

    assign dir_eff = (state_q == StIdle) ? DIR : dir_q;

    // Strobe history only records a low seen under DACK, so a strobe that
    // outlives a preemption cannot complete a beat.
    assign rd_beat = (state_q == StXfer) && DACK && IOR_N && !ior_q && (dir_eff == DIR_IO2MEM);
    assign wr_beat = (state_q == StXfer) && DACK && IOW_N && !iow_q && (dir_eff == DIR_MEM2IO);
    assign beat    = rd_beat || wr_beat;

    always_comb begin
        push      = 1'b0;
        pop       = 1'b0;
        push_data = loc_wdata;
        if (dir_eff == DIR_IO2MEM) begin
            push = loc_wvalid;
            pop  = rd_beat;
        end else begin
            push      = wr_beat;
            push_data = db_lat_q;
            pop       = loc_rready;
        end
    end

    assign pop_ok     = pop && !empty;
    assign push_ok    = push && (!full || pop_ok);
    assign cnt_nxt    = count + CW'(push_ok) - CW'(pop_ok);
    assign req_ok     = (dir_eff == DIR_IO2MEM) ? !empty : !full;
    assign req_ok_nxt = (dir_eff == DIR_IO2MEM) ? (cnt_nxt != '0) : (cnt_nxt != CW'(DEPTH));

    dma_dev_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RESET_N),
        .push      (push_ok),
        .push_data (push_data),
        .pop       (pop_ok),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state_q <= StIdle;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (DACK && !EOP_N) begin
            state_d = StHold;
        end else begin
            unique case (state_q)
                StIdle:  if (req_ok && !tc_q) state_d = StReq;
                StReq:   if (DACK) state_d = StXfer;
                StXfer: begin
                    if (!DACK)     state_d = StReq;
                    else if (beat) state_d = req_ok_nxt ? StReq : StIdle;
                end
                StHold:  if (tc_clear) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        dreq_act = (state_q == StReq) || (state_q == StXfer);
        DREQ     = DREQ_HIGH ? dreq_act : !dreq_act;
        DB_OE    = (state_q == StXfer) && DACK && !IOR_N && (dir_eff == DIR_IO2MEM);
        DB_OUT   = (DB_OE && !empty) ? head : '0;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            dir_q    <= DIR_IO2MEM;
            ior_q    <= 1'b1;
            iow_q    <= 1'b1;
            tc_q     <= 1'b0;
            db_lat_q <= '0;
        end else begin
            if (state_q == StIdle) dir_q <= DIR;
            ior_q <= IOR_N || !DACK;
            iow_q <= IOW_N || !DACK;
            if (DACK && !IOW_N) db_lat_q <= DB_IN;
            if (DACK && !EOP_N) tc_q <= 1'b1;
            else if (tc_clear)  tc_q <= 1'b0;
        end
    end

    assign tc_flag    = tc_q;
    assign loc_wready = !full && (dir_eff == DIR_IO2MEM);
    assign loc_rvalid = !empty && (dir_eff == DIR_MEM2IO);
    assign loc_rdata  = head;

endmodule

// File: tb/tb_dma_io_device.sv
// Scoreboard bench for dma_io_device: data pushed on either side is queued and
// compared when it emerges on the other side.
module tb_dma_io_device;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 8;

    logic              CLK = 1'b0;
    logic              RESET_N = 1'b0;
    logic              DIR = 1'b0;
    logic              DREQ;
    logic              DACK = 1'b0;
    logic              IOR_N = 1'b1;
    logic              IOW_N = 1'b1;
    logic              EOP_N = 1'b1;
    logic [DATA_W-1:0] DB_IN = '0;
    logic [DATA_W-1:0] DB_OUT;
    logic              DB_OE;
    logic              loc_wvalid = 1'b0;
    logic [DATA_W-1:0] loc_wdata = '0;
    logic              loc_wready;
    logic              loc_rvalid;
    logic [DATA_W-1:0] loc_rdata;
    logic              loc_rready = 1'b0;
    logic              tc_flag;
    logic              tc_clear = 1'b0;
    logic [$clog2(DEPTH):0] count;

    int total = 0;
    int bad   = 0;
    logic [DATA_W-1:0] sb[$];

    always #5 CLK = ~CLK;

    dma_io_device #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .DREQ_HIGH (1'b1)
    ) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .DIR        (DIR),
        .DREQ       (DREQ),
        .DACK       (DACK),
        .IOR_N      (IOR_N),
        .IOW_N      (IOW_N),
        .EOP_N      (EOP_N),
        .DB_IN      (DB_IN),
        .DB_OUT     (DB_OUT),
        .DB_OE      (DB_OE),
        .loc_wvalid (loc_wvalid),
        .loc_wdata  (loc_wdata),
        .loc_wready (loc_wready),
        .loc_rvalid (loc_rvalid),
        .loc_rdata  (loc_rdata),
        .loc_rready (loc_rready),
        .tc_flag    (tc_flag),
        .tc_clear   (tc_clear),
        .count      (count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input logic dir);
        DIR = dir; DACK = 1'b0; IOR_N = 1'b1; IOW_N = 1'b1; EOP_N = 1'b1;
        loc_wvalid = 1'b0; loc_rready = 1'b0; tc_clear = 1'b0;
        RESET_N = 1'b0;
        tick();
        tick();
        RESET_N = 1'b1;
        sb.delete();
    endtask

    task automatic wait_dreq(input string tag, input int budget);
        int n = 0;
        while (DREQ !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(DREQ), 32'd1);
    endtask

    task automatic loc_push(input logic [DATA_W-1:0] d);
        loc_wvalid = 1'b1;
        loc_wdata  = d;
        sb.push_back(d);
        tick();
        loc_wvalid = 1'b0;
    endtask

    task automatic rd_beat(input string tag, input logic eop, input logic clr,
                           input logic psh, input logic [DATA_W-1:0] pd);
        logic [DATA_W-1:0] e;
        IOR_N = 1'b0;
        tick();
        tick();
        check({tag, "_oe"}, 32'(DB_OE), 32'd1);
        e = (sb.size() > 0) ? sb[0] : 'x;
        check({tag, "_db"}, 32'(DB_OUT), 32'(e));
        if (sb.size() > 0) void'(sb.pop_front());
        IOR_N = 1'b1;
        EOP_N = !eop;
        tc_clear = clr;
        if (psh) begin
            loc_wvalid = 1'b1;
            loc_wdata  = pd;
            sb.push_back(pd);
        end
        tick();
        EOP_N = 1'b1;
        tc_clear = 1'b0;
        loc_wvalid = 1'b0;
    endtask

    task automatic wr_beat(input logic [DATA_W-1:0] d, input logic accepted);
        IOW_N = 1'b0;
        DB_IN = d;
        tick();
        tick();
        IOW_N = 1'b1;
        tick();
        if (accepted) sb.push_back(d);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [DATA_W-1:0] e;

        // Device to memory: two beats, demand mode between them.
        do_reset(1'b0);
        check("rst_dreq", 32'(DREQ), 32'd0);
        check("rst_oe", 32'(DB_OE), 32'd0);
        check("rst_db", 32'(DB_OUT), 32'd0);
        check("rst_tc", 32'(tc_flag), 32'd0);
        check("rst_cnt", 32'(count), 32'd0);
        loc_push(8'hA5);
        loc_push(8'h3C);
        check("t1_cnt2", 32'(count), 32'd2);
        wait_dreq("t1_dreq", 4);
        DACK = 1'b1;
        tick();
        rd_beat("t1_b1", 1'b0, 1'b0, 1'b0, '0);
        check("t1_cnt1", 32'(count), 32'd1);
        check("t1_dreq_hold", 32'(DREQ), 32'd1);
        rd_beat("t1_b2", 1'b0, 1'b0, 1'b0, '0);
        check("t1_cnt0", 32'(count), 32'd0);
        check("t1_dreq_drop", 32'(DREQ), 32'd0);
        DACK = 1'b0;
        tick();
        check("t1_idle", 32'(DREQ), 32'd0);

        // Memory to device: fill to DEPTH, ninth beat dropped, drain locally.
        do_reset(1'b1);
        wait_dreq("t2_dreq", 2);
        DACK = 1'b1;
        tick();
        IOR_N = 1'b0;
        tick();
        tick();
        check("t2_wrongdir_oe", 32'(DB_OE), 32'd0);
        IOR_N = 1'b1;
        tick();
        check("t2_wrongdir_cnt", 32'(count), 32'd0);
        for (int i = 0; i < 8; i++) wr_beat(8'(8'h10 + i), 1'b1);
        check("t2_cnt8", 32'(count), 32'd8);
        check("t2_dreq_full", 32'(DREQ), 32'd0);
        wr_beat(8'h18, 1'b0);
        check("t2_drop9", 32'(count), 32'd8);
        DACK = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("t2_rvalid", 32'(loc_rvalid), 32'd1);
            e = (sb.size() > 0) ? sb[0] : 'x;
            check("t2_rdata", 32'(loc_rdata), 32'(e));
            if (sb.size() > 0) void'(sb.pop_front());
            loc_rready = 1'b1;
            tick();
            loc_rready = 1'b0;
        end
        check("t2_drained", 32'(count), 32'd0);

        // Terminal count on the first beat, sticky until cleared.
        do_reset(1'b0);
        loc_push(8'h21);
        loc_push(8'h22);
        loc_push(8'h23);
        wait_dreq("t3_dreq", 4);
        DACK = 1'b1;
        tick();
        rd_beat("t3_eop", 1'b1, 1'b0, 1'b0, '0);
        check("t3_cnt2", 32'(count), 32'd2);
        check("t3_tc", 32'(tc_flag), 32'd1);
        check("t3_dreq_off", 32'(DREQ), 32'd0);
        DACK = 1'b0;
        repeat (5) tick();
        check("t3_hold", 32'(DREQ), 32'd0);
        tc_clear = 1'b1;
        tick();
        tc_clear = 1'b0;
        check("t3_tc_clr", 32'(tc_flag), 32'd0);
        wait_dreq("t3_rereq", 2);
        DACK = 1'b1;
        tick();
        rd_beat("t3_b2", 1'b0, 1'b0, 1'b0, '0);
        rd_beat("t3_b3", 1'b1, 1'b1, 1'b0, '0);
        check("t3_eop_wins", 32'(tc_flag), 32'd1);
        DACK = 1'b0;
        tc_clear = 1'b1;
        tick();
        tc_clear = 1'b0;
        check("t3_tc_clr2", 32'(tc_flag), 32'd0);

        // Preemption: DACK drops before IOR_N rises.
        loc_push(8'h44);
        wait_dreq("t4_dreq", 4);
        DACK = 1'b1;
        tick();
        IOR_N = 1'b0;
        tick();
        tick();
        DACK = 1'b0;
        tick();
        IOR_N = 1'b1;
        tick();
        check("t4_nopop", 32'(count), 32'd1);
        check("t4_dreq", 32'(DREQ), 32'd1);
        DACK = 1'b1;
        tick();
        rd_beat("t4_b", 1'b0, 1'b0, 1'b0, '0);
        check("t4_cnt0", 32'(count), 32'd0);
        DACK = 1'b0;
        tick();

        // Full FIFO with a local push on every beat; pointers wrap 3x.
        for (int i = 0; i < 8; i++) loc_push(8'(8'h80 + i));
        check("t6_full", 32'(count), 32'd8);
        wait_dreq("t6_dreq", 4);
        DACK = 1'b1;
        tick();
        for (int k = 0; k < 3 * DEPTH; k++) begin
            rd_beat("t6_wrap", 1'b0, 1'b0, 1'b1, 8'(8'h90 + k));
            check("t6_cnt", 32'(count), 32'd8);
        end
        for (int k = 0; k < DEPTH; k++) rd_beat("t6_drain", 1'b0, 1'b0, 1'b0, '0);
        check("t6_empty", 32'(count), 32'd0);
        check("t6_dreq_off", 32'(DREQ), 32'd0);
        DACK = 1'b0;
        tick();

        // Asynchronous reset in the middle of a beat.
        loc_push(8'h55);
        wait_dreq("t5_dreq", 4);
        DACK = 1'b1;
        tick();
        IOR_N = 1'b0;
        tick();
        tick();
        check("t5_oe_pre", 32'(DB_OE), 32'd1);
        #2;
        RESET_N = 1'b0;
        #1;
        check("t5_dreq", 32'(DREQ), 32'd0);
        check("t5_oe", 32'(DB_OE), 32'd0);
        check("t5_tc", 32'(tc_flag), 32'd0);
        check("t5_cnt", 32'(count), 32'd0);
        tick();
        IOR_N = 1'b1;
        DACK = 1'b0;
        RESET_N = 1'b1;
        sb.delete();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dma_io_device.md
Name: dma_io_device

Overview:
- Peripheral-side endpoint of the DMA channel handshake; the responder opposite the DMA controller's timing-and-control FSM.
- Raises DREQ when it has data to send or room to receive.
- After DACK, sources data on IOR_N (I/O-to-memory, DMA write transfer) or sinks data on IOW_N (memory-to-I/O, DMA read transfer).
- Buffers local-side data in a small FIFO. Serves as the device model on the DMA bench and as a synthesizable endpoint.

Parameters:
- DATA_W, 8, data bus width.
- DEPTH, 8, FIFO entries; power of two, ≥2.
- DREQ_HIGH, 1, DREQ active level (1 = active-high, as the controller's default programming).

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RESET_N  in  1  asynchronous active-low reset.
- DIR  in  1  0 = device→memory (responds to IOR_N), 1 = memory→device (responds to IOW_N); sampled only in IDLE.
- DREQ  out  1  DMA request to controller.
- DACK  in  1  DMA acknowledge for this channel, active-high.
- IOR_N  in  1  I/O read strobe, active-low.
- IOW_N  in  1  I/O write strobe, active-low.
- EOP_N  in  1  end-of-process / terminal count, active-low.
- DB_IN  in  DATA_W  data bus from the system side.
- DB_OUT  out  DATA_W  data bus toward the system side.
- DB_OE  out  1  DB_OUT output enable.
- loc_wvalid  in  1  local push valid (DIR=0 data source).
- loc_wdata  in  DATA_W  local push data.
- loc_wready  out  1  FIFO not full and DIR=0.
- loc_rvalid  out  1  FIFO not empty and DIR=1.
- loc_rdata  out  DATA_W  FIFO head.
- loc_rready  in  1  local pop.
- tc_flag  out  1  sticky terminal-count seen.
- tc_clear  in  1  clears tc_flag.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset, asynchronous:
  - FSM → IDLE; FIFO emptied; count=0.
  - DREQ inactive; DB_OE=0; DB_OUT=0; tc_flag=0.
  - Strobe history registers = 1 (deasserted).
- States (shared enum):
  - IDLE: no request.
  - REQ: DREQ active, waiting for DACK.
  - XFER: DACK seen, waiting for the strobe to assert and then deassert.
  - HOLD: tc_flag set, waiting for tc_clear.
- Request condition (req_ok):
  - DIR=0: count>0.
  - DIR=1: count<DEPTH.
- Transitions:
  - IDLE→REQ when req_ok and !tc_flag.
  - REQ→XFER when DACK=1.
  - XFER→REQ on a completed beat while req_ok still holds (demand mode: DREQ stays asserted).
  - XFER→IDLE on a completed beat when !req_ok; DREQ drops the cycle after the beat.
  - Any state→HOLD when DACK=1 and EOP_N=0 are sampled together, the same cycle as any beat. Beat completes, DREQ inactive next cycle.
  - HOLD→IDLE when tc_clear=1.
- DREQ is registered: active in REQ and XFER, inactive otherwise.
- DACK low while in XFER (controller preemption):
  - Return to REQ, no data movement.
  - A partially asserted strobe without DACK is ignored.
- Beat, DIR=0:
  - While DACK=1 and IOR_N=0: DB_OE=1, DB_OUT=FIFO head (combinational from head).
  - On the first cycle IOR_N is sampled 1 after having been 0 with DACK=1 (rising edge via registered IOR_N): pop one entry.
- Beat, DIR=1:
  - DB_IN is latched every cycle that DACK=1 and IOW_N=0.
  - On the IOW_N rising edge: push the last latched value.
- A strobe for the wrong DIR is ignored (no push/pop, DB_OE=0).
- Overflow/underflow guard: a beat with the FIFO empty (DIR=0) or full (DIR=1) is dropped. No pointer movement. DB_OUT=0.
- FIFO and pointers:
  - Local and bus-side operations in the same cycle are both performed.
  - Count is net ±0/±1.
  - Pointers wrap modulo DEPTH.
- Latency:
  - Local push to DREQ active: 2 cycles (count update, then FSM/DREQ register).
- tc_clear and EOP in the same cycle: EOP wins; tc_flag stays set.

Decomposition:
- Package dma_dev_pkg:
  - state enum {IDLE, REQ, XFER, HOLD}, one-hot encoding.
  - DIR_IO2MEM=0, DIR_MEM2IO=1.
- Sub-module dma_dev_fifo: synchronous FIFO with push/pop/full/empty/count. Async active-low reset; simultaneous push+pop allowed when full or empty per occupancy rules.
- Top holds the FSM, strobe edge detect, and bus muxing.

Test Plan:
- DIR=0, push 0xA5,0x3C locally; DACK=1 after DREQ; two IOR_N pulses of 2 cycles each → DB_OUT=0xA5 then 0x3C while IOR_N low with DB_OE=1; count 2→1→0; DREQ low 1 cycle after second beat; FSM returns to IDLE.
- DIR=1, empty FIFO, DEPTH=8 → DREQ high within 2 cycles of reset release. Drive 8 IOW_N beats with DB_IN=0x10..0x17 → count=8, DREQ low after 8th beat. 9th beat dropped. loc_rdata pops 0x10..0x17 in order.
- DIR=0, 3 entries; EOP_N=0 with DACK on the first beat → one pop (count=2), tc_flag=1, DREQ inactive. DREQ stays low despite count>0 until tc_clear. Then DREQ reasserts within 2 cycles.
- DACK drops mid-XFER before IOR_N rises → no pop, state REQ, DREQ still active; a later full beat pops normally.
- Assert RESET_N=0 asynchronously mid-beat with IOR_N=0 → DREQ, DB_OE, tc_flag, count all 0 immediately, before the next CLK edge.
- Simultaneous local push and IOR_N-completed pop at count=DEPTH → count stays DEPTH, data order preserved; wrap-around checked over 3×DEPTH beats.
